core_seq: RTL

- Parametrised sequencer for the compute core. Replaces the hand-driven 35-bit instruction word with on-chip control.
- Runs N kernel positions (kij), each in three phases: stream activations from activation SRAM into L0, execute through the PE array, drain OFIFO results into psum SRAM.
- Drives the SRAM and corelet control strobes; the datapath is unchanged.

---
 rtl/core_seq_if.sv | 39 +++
 rtl/core_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/core_seq_if.sv
// Control bundle between the compute-core sequencer and the SRAM/corelet datapath.
// The sequencer sits on the slave modport; whatever issues commands sits on master.
interface core_seq_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned KIJ_W  = 4
);
    logic              start;
    logic [LEN_W-1:0]  num_rows;
    logic [KIJ_W-1:0]  num_kij;
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] p_base;
    logic              ofifo_valid;
    logic              xmem_cen;
    logic              xmem_wen;
    logic [ADDR_W-1:0] xmem_addr;
    logic              l0_wr;
    logic              l0_rd;
    logic              execute;
    logic              ofifo_rd;
    logic              pmem_cen;
    logic              pmem_wen;
    logic [ADDR_W-1:0] pmem_addr;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, num_rows, num_kij, x_base, p_base, ofifo_valid,
        input  xmem_cen, xmem_wen, xmem_addr, l0_wr, l0_rd, execute, ofifo_rd,
        input  pmem_cen, pmem_wen, pmem_addr, busy, done, err
    );

    modport slave (
        input  start, num_rows, num_kij, x_base, p_base, ofifo_valid,
        output xmem_cen, xmem_wen, xmem_addr, l0_wr, l0_rd, execute, ofifo_rd,
        output pmem_cen, pmem_wen, pmem_addr, busy, done, err
    );
endinterface

// File: rtl/core_seq.sv
// Compute-core sequencer: per kernel position, stream activations into L0, execute the
// PE array, then drain OFIFO rows into psum SRAM.
module core_seq #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned KIJ_W    = 4,
    parameter int unsigned DRAIN_TO = 64
) (
    input  logic      clk,
    input  logic      reset,
    core_seq_if.slave bus
);
    localparam int unsigned TO_W = $clog2(DRAIN_TO + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] EXEC  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] NEXT  = 3'd4;
    localparam logic [2:0] FIN   = 3'd5;

    logic [2:0]        stateQ, stateD;
    logic [LEN_W-1:0]  numRowsQ, numRowsD, cntQ, cntD;
    logic [KIJ_W-1:0]  numKijQ, numKijD, kijQ, kijD;
    logic [ADDR_W-1:0] xBaseQ, xBaseD, pBaseQ, pBaseD, kijOffQ, kijOffD;
    logic [ADDR_W-1:0] xAddrQ, xAddrD, pAddrQ, pAddrD;
    logic [TO_W-1:0]   idleQ, idleD;
    logic              xCenQ, xCenD, l0WrQ, execQ, execD, pCenQ, pCenD;
    logic              busyQ, doneQ, doneD, errQ, errD;
    logic              pop;

    // The pop must coincide with the cycle ofifo_valid is seen, otherwise a level-valid
    // FIFO would be popped twice for one row; it is decoded from registered state only.
    assign pop = (stateQ == DRAIN) && bus.ofifo_valid && (cntQ != numRowsQ);

    always_comb begin
        stateD   = stateQ;
        numRowsD = numRowsQ;
        numKijD  = numKijQ;
        xBaseD   = xBaseQ;
        pBaseD   = pBaseQ;
        cntD     = cntQ;
        kijD     = kijQ;
        kijOffD  = kijOffQ;
        idleD    = idleQ;
        errD     = errQ;
        xCenD    = 1'b1;
        xAddrD   = xAddrQ;
        execD    = 1'b0;
        pCenD    = 1'b1;
        pAddrD   = pAddrQ;
        doneD    = 1'b0;
        case (stateQ)
            IDLE: begin
                if (bus.start) begin
                    if ((bus.num_rows != '0) && (bus.num_kij != '0)) begin
                        numRowsD = bus.num_rows;
                        numKijD  = bus.num_kij;
                        xBaseD   = bus.x_base;
                        pBaseD   = bus.p_base;
                        cntD     = '0;
                        kijD     = '0;
                        kijOffD  = '0;
                        errD     = 1'b0;
                        stateD   = LOAD;
                    end else begin
                        errD = 1'b1;
                    end
                end
            end
            LOAD: begin
                // One extra cycle after the last read lets its l0_wr land before EXEC.
                if (cntQ != numRowsQ) begin
                    xCenD  = 1'b0;
                    xAddrD = xBaseQ + kijOffQ + ADDR_W'(cntQ);
                    cntD   = cntQ + LEN_W'(1);
                end else begin
                    cntD   = '0;
                    stateD = EXEC;
                end
            end
            EXEC: begin
                execD = 1'b1;
                if (cntQ == numRowsQ - LEN_W'(1)) begin
                    cntD   = '0;
                    idleD  = '0;
                    stateD = DRAIN;
                end else begin
                    cntD = cntQ + LEN_W'(1);
                end
            end
            DRAIN: begin
                if (pop) begin
                    pCenD  = 1'b0;
                    pAddrD = pBaseQ + kijOffQ + ADDR_W'(cntQ);
                    cntD   = cntQ + LEN_W'(1);
                end
                if (bus.ofifo_valid) begin
                    idleD = '0;
                end else if (cntQ != numRowsQ) begin
                    if (idleQ == TO_W'(DRAIN_TO - 1)) begin
                        errD   = 1'b1;
                        stateD = IDLE;
                    end else begin
                        idleD = idleQ + TO_W'(1);
                    end
                end
                // Leave only once the final psum write has been on the bus for its cycle.
                if ((cntQ == numRowsQ) && pCenQ) begin
                    stateD = NEXT;
                end
            end
            NEXT: begin
                kijD    = kijQ + KIJ_W'(1);
                kijOffD = kijOffQ + ADDR_W'(numRowsQ);
                cntD    = '0;
                stateD  = (kijD == numKijQ) ? FIN : LOAD;
            end
            FIN: begin
                doneD  = 1'b1;
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ   <= IDLE;
            numRowsQ <= '0;
            numKijQ  <= '0;
            xBaseQ   <= '0;
            pBaseQ   <= '0;
            cntQ     <= '0;
            kijQ     <= '0;
            kijOffQ  <= '0;
            idleQ    <= '0;
            xCenQ    <= 1'b1;
            xAddrQ   <= '0;
            l0WrQ    <= 1'b0;
            execQ    <= 1'b0;
            pCenQ    <= 1'b1;
            pAddrQ   <= '0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            errQ     <= 1'b0;
        end else begin
            stateQ   <= stateD;
            numRowsQ <= numRowsD;
            numKijQ  <= numKijD;
            xBaseQ   <= xBaseD;
            pBaseQ   <= pBaseD;
            cntQ     <= cntD;
            kijQ     <= kijD;
            kijOffQ  <= kijOffD;
            idleQ    <= idleD;
            xCenQ    <= xCenD;
            xAddrQ   <= xAddrD;
            l0WrQ    <= ~xCenQ;
            execQ    <= execD;
            pCenQ    <= pCenD;
            pAddrQ   <= pAddrD;
            busyQ    <= (stateD != IDLE);
            doneQ    <= doneD;
            errQ     <= errD;
        end
    end

    assign bus.xmem_cen  = xCenQ;
    assign bus.xmem_wen  = 1'b1;
    assign bus.xmem_addr = xAddrQ;
    assign bus.l0_wr     = l0WrQ;
    assign bus.l0_rd     = execQ;
    assign bus.execute   = execQ;
    assign bus.ofifo_rd  = pop;
    assign bus.pmem_cen  = pCenQ;
    assign bus.pmem_wen  = pCenQ;
    assign bus.pmem_addr = pAddrQ;
    assign bus.busy      = busyQ;
    assign bus.done      = doneQ;
    assign bus.err       = errQ;
endmodule
